sprite_renderer: RTL and testbench
==================================

Name: sprite_renderer

Overview:
Parametrised sprite pixel generator for the VGA path. It maps the current scan position (DrawX, DrawY) onto an animated, power-of-two-scaled sprite at a runtime position and issues the sprite ROM address. It pipelines the hit, blank and ROM result to produce a palette index plus a pixel-valid flag for the downstream compositor. It also owns an animation frame sequencer advanced once per video frame.

Parameters:
SPR_W, 32, sprite width in texels (power of two)
SPR_H, 32, sprite height in texels (power of two)
NUM_FRAMES, 4, animation frames stored back-to-back in ROM
SCALE_SHIFT, 1, on-screen scale = 2**SCALE_SHIFT pixels per texel
ROM_LAT, 1, ROM read latency in cycles (>=1)
PAL_BITS, 3, palette index width
TRANSP_IDX, 0, palette index treated as transparent
FRAME_TICKS, 8, video frames per animation step (>=1)
ADDR_W, 12, ROM address width; must satisfy 2**ADDR_W >= SPR_W*SPR_H*NUM_FRAMES

Ports:
vga_clk  in  1  pixel clock, sole clock
reset  in  1  synchronous, active-high reset
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
blank  in  1  1 = active video
sprite_x  in  10  sprite top-left column (screen pixels)
sprite_y  in  10  sprite top-left row
anim_en  in  1  1 = animation advances
rom_address  out  ADDR_W  registered ROM read address
rom_q  in  PAL_BITS  ROM data, valid ROM_LAT cycles after rom_address
pixel_index  out  PAL_BITS  palette index for compositor
pixel_on  out  1  1 = opaque sprite pixel in active video
anim_frame  out  log2(NUM_FRAMES) (min 1)  current animation frame

Behaviour:
- Reset (sync, active-high, wins over everything): rom_address=0, pixel_index=0, pixel_on=0, anim_frame=0, tick counter=0, pipeline valid bits=0.
- Hit test (stage 0, combinational): hit = DrawX>=sprite_x && DrawX<sprite_x+(SPR_W<<SCALE_SHIFT) && same for Y with SPR_H. Compare in 11 bits; no 10-bit wrap, so sprites extending past column/row 1023 are clipped, not wrapped.
- lx=(DrawX-sprite_x)>>SCALE_SHIFT, ly=(DrawY-sprite_y)>>SCALE_SHIFT; address = anim_frame*SPR_W*SPR_H + ly*SPR_W + lx. Use shifts only, no dividers or multipliers. On no hit, registered rom_address = 0.
- Cycle 1: rom_address registered. Cycle 1+ROM_LAT: rom_q valid. Cycle 2+ROM_LAT: outputs registered. hit and blank travel through a (1+ROM_LAT)-deep shift register aligned to rom_q.
- Output stage: pixel_on = hit_d & blank_d & (rom_q != TRANSP_IDX). pixel_index = rom_q when pixel_on, else 0.
- Total latency from DrawX/DrawY to pixel_on/pixel_index = ROM_LAT+2 cycles, fixed. The upstream VGA controller delays its sync signals to match.
- Frame sequencer:
  - frame_start = one-cycle pulse on the first cycle where DrawX==0 && DrawY==0, detected by registered previous state.
  - On frame_start with anim_en=1: tick increments. At tick==FRAME_TICKS-1, tick resets to 0 and anim_frame advances, wrapping NUM_FRAMES-1 -> 0.
  - anim_en=0: tick and anim_frame hold.
  - FRAME_TICKS=1: advance every frame.
- anim_frame updates only at frame_start, so no mid-frame tearing. Frame data already in the pipeline completes with the old frame.
- sprite_x/sprite_y are sampled every cycle; the compositor/game logic changes them only during blanking.
- Reset mid-frame: pipeline flushes to pixel_on=0 on the next edge. Normal output resumes ROM_LAT+2 cycles after reset deasserts.

Optional Feature:
SPRITE_MIRROR_EN: when defined, adds input port flip_x (1 bit). flip_x=1 uses lx' = SPR_W-1-lx for horizontal mirroring. flip_x is latched at frame_start, so mirroring changes only on frame boundaries. When undefined, the port is absent and lx is used directly.

Test Plan:
- Reset held 3 cycles mid-line at DrawX=100 -> pixel_on=0, anim_frame=0, rom_address=0. First valid output exactly 3 cycles (ROM_LAT=1) after release.
- sprite_x=100, sprite_y=50, DrawY=50, sweep DrawX 98..166 -> rom_address 0 for DrawX 98,99; addresses 0,0,1,1,...,31,31 for DrawX 100..163; 0 from DrawX 164 on. pixel_on follows 3 cycles later.
- ROM model returns TRANSP_IDX=0 at address 5, other addresses return 3 -> pixel_on=0 at DrawX 110,111; elsewhere pixel_on=1 with pixel_index=3.
- blank=0 while hit -> pixel_on=0 and pixel_index=0 at the aligned output cycle.
- anim_en=1, 8 frame_starts -> anim_frame 0->1; after 32 -> back to 0. Frame 2 pixel (0,0) gives rom_address=2048. anim_en=0 for 8 frames -> anim_frame unchanged.
- SPRITE_MIRROR_EN defined, flip_x=1 latched at frame_start, DrawX=100 on sprite row 0 -> rom_address=31. flip_x toggled mid-frame -> no change until the next frame_start.

Source files
------------

// File: rtl/sprite_renderer.sv
// Scaled, animated sprite pixel generator: hit test, ROM addressing, ROM-aligned output stage
// and a per-frame animation sequencer. Define SPRITE_MIRROR_EN to add the flip_x mirroring input.
module sprite_renderer #(
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int NUM_FRAMES  = 4,
    parameter int SCALE_SHIFT = 1,
    parameter int ROM_LAT     = 1,
    parameter int PAL_BITS    = 3,
    parameter int TRANSP_IDX  = 0,
    parameter int FRAME_TICKS = 8,
    parameter int ADDR_W      = 12
) (
    input  logic                vga_clk,
    input  logic                reset,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic                blank,
    input  logic [9:0]          sprite_x,
    input  logic [9:0]          sprite_y,
    input  logic                anim_en,
    output logic [ADDR_W-1:0]   rom_address,
    input  logic [PAL_BITS-1:0] rom_q,
    output logic [PAL_BITS-1:0] pixel_index,
    output logic                pixel_on,
    output logic [((NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1)-1:0] anim_frame
`ifdef SPRITE_MIRROR_EN
    ,
    input  logic                flip_x
`endif
);

    localparam int AF_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int TK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int LX_W = $clog2(SPR_W);
    localparam int LY_W = $clog2(SPR_H);

    localparam logic [10:0]         SPAN_X     = 11'(SPR_W << SCALE_SHIFT);
    localparam logic [10:0]         SPAN_Y     = 11'(SPR_H << SCALE_SHIFT);
    localparam logic [10:0]         LX_MAX     = 11'(SPR_W - 1);
    localparam logic [TK_W-1:0]     TICK_LAST  = TK_W'(FRAME_TICKS - 1);
    localparam logic [AF_W-1:0]     FRAME_LAST = AF_W'(NUM_FRAMES - 1);
    localparam logic [PAL_BITS-1:0] TRANSP     = PAL_BITS'(TRANSP_IDX);

    // Frames are stored back-to-back, rows of SPR_W texels; power-of-two sizes make this pure shifts.
    function automatic logic [ADDR_W-1:0] tex_addr(input logic [AF_W-1:0] frame,
                                                   input logic [10:0]     lx,
                                                   input logic [10:0]     ly);
        logic [31:0] a;
        a = (32'(frame) << (LX_W + LY_W))
          | ((32'(ly) & 32'(SPR_H - 1)) << LX_W)
          | (32'(lx) & 32'(SPR_W - 1));
        return ADDR_W'(a);
    endfunction

    logic [10:0]       pos_x, pos_y, org_x, org_y;
    logic [10:0]       dx_p0, dy_p0, lx_p0, ly_p0;
    logic              hit_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic              flip_p0;

    logic [ROM_LAT:0]  hit_sr;
    logic [ROM_LAT:0]  blank_sr;
    logic              opaque;

    logic              prev_origin;
    logic              frame_start;
    logic [TK_W-1:0]   tick;

`ifdef SPRITE_MIRROR_EN
    logic              flip_lat;
    assign flip_p0 = flip_lat;
`else
    assign flip_p0 = 1'b0;
`endif

    // Stage 0: 11-bit hit test (clips past column/row 1023) and texel address
    always_comb begin
        pos_x  = {1'b0, DrawX};
        pos_y  = {1'b0, DrawY};
        org_x  = {1'b0, sprite_x};
        org_y  = {1'b0, sprite_y};
        hit_p0 = (pos_x >= org_x) && (pos_x < org_x + SPAN_X)
              && (pos_y >= org_y) && (pos_y < org_y + SPAN_Y);
        dx_p0  = pos_x - org_x;
        dy_p0  = pos_y - org_y;
        lx_p0  = dx_p0 >> SCALE_SHIFT;
        ly_p0  = dy_p0 >> SCALE_SHIFT;
        if (flip_p0)
            lx_p0 = LX_MAX - lx_p0;
        addr_p0 = tex_addr(anim_frame, lx_p0, ly_p0);
    end

    assign opaque      = hit_sr[ROM_LAT] && blank_sr[ROM_LAT] && (rom_q != TRANSP);
    assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0) && !prev_origin;

    // Stage 1 registers the address; hit/blank ride a shift register so they line up with rom_q
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            rom_address <= '0;
            hit_sr      <= '0;
            blank_sr    <= '0;
            pixel_on    <= 1'b0;
            pixel_index <= '0;
        end else begin
            rom_address <= hit_p0 ? addr_p0 : '0;
            hit_sr      <= {hit_sr[ROM_LAT-1:0], hit_p0};
            blank_sr    <= {blank_sr[ROM_LAT-1:0], blank};
            pixel_on    <= opaque;
            pixel_index <= opaque ? rom_q : '0;
        end
    end

    // Animation state changes only at the start of a frame, so a frame never tears
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            prev_origin <= 1'b0;
            tick        <= '0;
            anim_frame  <= '0;
`ifdef SPRITE_MIRROR_EN
            flip_lat    <= 1'b0;
`endif
        end else begin
            prev_origin <= (DrawX == 10'd0) && (DrawY == 10'd0);
            if (frame_start) begin
                if (anim_en) begin
                    if (tick == TICK_LAST) begin
                        tick       <= '0;
                        anim_frame <= (anim_frame == FRAME_LAST) ? '0 : anim_frame + 1'b1;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
`ifdef SPRITE_MIRROR_EN
                flip_lat <= flip_x;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer: stimulus queues expected address/pixel results with
// their due cycle, a negedge monitor pops and compares them.
module tb_sprite_renderer;

    localparam int SPR_W = 32;
    localparam int SPR_H = 32;
    localparam int SCALE = 2;

    logic       vga_clk = 1'b0;
    logic       reset;
    logic [9:0] DrawX, DrawY, sprite_x, sprite_y;
    logic       blank, anim_en;
    logic [11:0] rom_address;
    logic [2:0]  rom_q;
    logic [2:0]  pixel_index;
    logic        pixel_on;
    logic [1:0]  anim_frame;
`ifdef SPRITE_MIRROR_EN
    logic        flip_x;
`endif

    sprite_renderer dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .anim_en    (anim_en),
        .rom_address(rom_address),
        .rom_q      (rom_q),
        .pixel_index(pixel_index),
        .pixel_on   (pixel_on),
        .anim_frame (anim_frame)
`ifdef SPRITE_MIRROR_EN
        ,
        .flip_x     (flip_x)
`endif
    );

    always #5 vga_clk = ~vga_clk;

    // Address 5 holds the transparent index, everything else palette entry 3
    function automatic logic [2:0] rom_fn(input logic [11:0] a);
        return (a == 12'd5) ? 3'd0 : 3'd3;
    endfunction

    always @(posedge vga_clk) rom_q <= rom_fn(rom_address);

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int a;
        int b;
    } item_t;

    item_t aq[$];
    item_t pq[$];

    int total = 0;
    int bad   = 0;

    int sx, sy;
    int exp_frame = 0;
    bit exp_flip  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    always @(negedge vga_clk) begin
        item_t it;
        while (aq.size() > 0 && aq[0].due <= cyc) begin
            it = aq.pop_front();
            check("rom_address", 32'(rom_address), 32'(it.a));
        end
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            it = pq.pop_front();
            check("pixel_on", 32'(pixel_on), 32'(it.a));
            check("pixel_index", 32'(pixel_index), 32'(it.b));
        end
    end

    task automatic set_sprite(input int x, input int y);
        sx = x;
        sy = y;
        sprite_x = 10'(x);
        sprite_y = 10'(y);
    endtask

    // Drive one pixel and queue what must come out 1 (address) and 3 (pixel) edges later
    task automatic step(input int x, input int y, input bit b);
        item_t ai, pi;
        bit hit, on;
        int lx, ly, ea;
        logic [2:0] rv;
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        hit = (x >= sx) && (x < sx + SPR_W * SCALE) && (y >= sy) && (y < sy + SPR_H * SCALE);
        lx  = (x - sx) / SCALE;
        ly  = (y - sy) / SCALE;
        if (exp_flip) lx = SPR_W - 1 - lx;
        ea  = hit ? (exp_frame * SPR_W * SPR_H + ly * SPR_W + lx) : 0;
        rv  = rom_fn(12'(ea));
        on  = hit && b && (rv != 3'd0);
        ai.due = cyc + 1; ai.a = ea; ai.b = 0;
        pi.due = cyc + 3; pi.a = int'(on); pi.b = on ? int'(rv) : 0;
        aq.push_back(ai);
        pq.push_back(pi);
        @(posedge vga_clk);
        #1;
    endtask

    task automatic frame_pulse();
        step(0, 0, 1'b0);
        step(1, 0, 1'b0);
    endtask

    initial begin
        item_t z;
        reset   = 1'b1;
        DrawX   = 10'd100;
        DrawY   = 10'd50;
        blank   = 1'b1;
        anim_en = 1'b0;
`ifdef SPRITE_MIRROR_EN
        flip_x  = 1'b0;
`endif
        set_sprite(100, 50);

        // Reset held for three edges mid-line
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        check("reset_pixel_on", 32'(pixel_on), 32'd0);
        check("reset_anim_frame", 32'(anim_frame), 32'd0);
        check("reset_rom_address", 32'(rom_address), 32'd0);
        check("reset_pixel_index", 32'(pixel_index), 32'd0);
        reset = 1'b0;
        z.a = 0; z.b = 0;
        z.due = cyc + 1; pq.push_back(z);
        z.due = cyc + 2; pq.push_back(z);
        step(100, 50, 1'b1);

        // Horizontal sweep across row 0, with a blanked pair inside the sprite
        for (int x = 98; x <= 166; x++)
            step(x, 50, !(x == 130 || x == 131));

        // Vertical edges and the last sprite row
        step(100, 49, 1'b1);
        step(101, 113, 1'b1);
        step(100, 114, 1'b1);

        // Right-edge clipping: no wrap through column 0
        set_sprite(1000, 50);
        step(1023, 50, 1'b1);
        step(10, 50, 1'b1);
        step(0, 50, 1'b1);
        set_sprite(100, 50);

        // Animation: 8 frame starts per step, 4 frames
        anim_en = 1'b1;
        repeat (7) frame_pulse();
        @(negedge vga_clk);
        check("anim_after_7", 32'(anim_frame), 32'd0);
        frame_pulse();
        @(negedge vga_clk);
        check("anim_after_8", 32'(anim_frame), 32'd1);
        repeat (24) frame_pulse();
        @(negedge vga_clk);
        check("anim_after_32", 32'(anim_frame), 32'd0);
        repeat (16) frame_pulse();
        @(negedge vga_clk);
        check("anim_after_48", 32'(anim_frame), 32'd2);

        // Frame 2 texel (0,0) with the sprite at the origin
        anim_en   = 1'b0;
        exp_frame = 2;
        set_sprite(0, 0);
        step(5, 5, 1'b1);
        step(0, 0, 1'b1);
        step(3, 0, 1'b1);
        set_sprite(100, 50);
        repeat (8) frame_pulse();
        @(negedge vga_clk);
        check("anim_hold", 32'(anim_frame), 32'd2);
        step(104, 52, 1'b1);

`ifdef SPRITE_MIRROR_EN
        flip_x = 1'b1;
        frame_pulse();
        exp_flip = 1'b1;
        step(100, 50, 1'b1);
        flip_x = 1'b0;
        step(100, 50, 1'b1);
        step(163, 50, 1'b1);
        frame_pulse();
        exp_flip = 1'b0;
        step(100, 50, 1'b1);
`endif

        repeat (6) @(posedge vga_clk);
        @(negedge vga_clk);
        total = total + 1;
        if (aq.size() != 0 || pq.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain: %0d address and %0d pixel results never checked, expected 0",
                     aq.size(), pq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "timeout");
    end

endmodule
